// File: rtl/core_pkg.sv
// Shared load-unit definitions: func_3 encodings, FSM state type and access-size decode.
package core_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } t_load_state;

  // Access size in bytes (1, 2, 4 or 8) selected by func_3[1:0].
  function automatic logic [3:0] access_size(input logic [2:0] func_3);
    logic [3:0] size_s;
    case (func_3[1:0])
      2'b00:   size_s = 4'd1;
      2'b01:   size_s = 4'd2;
      2'b10:   size_s = 4'd4;
      2'b11:   size_s = 4'd8;
      default: size_s = 4'd1;
    endcase
    return size_s;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational field extraction: shift the two-word window by the byte offset,
// keep the access size and sign/zero-extend to a full word.
module load_extract
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int OFFS_W     = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] hi,
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [OFFS_W-1:0]     offset,
  input  logic [2:0]            func_3,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int SH_W = $clog2(2 * DATA_WIDTH);

  logic [2*DATA_WIDTH-1:0] shifted_s;
  logic [6:0]              nbits_s;
  logic [SH_W-1:0]         msb_idx_s;
  logic                    sign_s;

  // Bits above the field take the field MSB for signed loads, zero otherwise.
  always_comb begin
    shifted_s = {hi, lo} >> {offset, 3'b000};
    nbits_s   = {access_size(func_3), 3'b000};
    msb_idx_s = SH_W'(nbits_s - 7'd1);
    sign_s    = ~func_3[2] & shifted_s[msb_idx_s];
    result    = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (7'(i) < nbits_s) begin
        result[i] = shifted_s[i];
      end else begin
        result[i] = sign_s;
      end
    end
  end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load unit: issues one or two aligned reads per load, merges and
// extends the selected field, and returns it over a valid/ready handshake.
module load_align_unit
  import core_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [2:0]            i_req_func_3,
  output logic                  o_mem_valid,
  input  logic                  i_mem_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_load_addr_ma,
  output logic                  o_illegal_instr
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFFS_W = $clog2(BYTES);

  t_load_state           state_r;
  t_load_state           state_next_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [2:0]            func_3_r;
  logic                  cross_r;
  logic [DATA_WIDTH-1:0] lo_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;
  logic                  ma_r;
  logic                  ill_r;

  logic                  illegal_s;
  logic                  cross_s;
  logic [ADDR_WIDTH-1:0] aligned_s;
  logic [DATA_WIDTH-1:0] ext_lo_s;
  logic [DATA_WIDTH-1:0] ext_hi_s;
  logic [DATA_WIDTH-1:0] ext_data_s;

  // Request decode; LD and LWU do not exist on a 32-bit datapath.
  always_comb begin
    illegal_s = (i_req_func_3 == F3_BAD) |
                ((DATA_WIDTH == 32) & ((i_req_func_3 == F3_LD) | (i_req_func_3 == F3_LWU)));
    cross_s   = (5'(i_req_addr[OFFS_W-1:0]) + 5'(access_size(i_req_func_3))) > 5'(BYTES);
  end

  // The beat arriving this cycle feeds the extractor directly so the response
  // register can load on the same edge that enters RESP.
  always_comb begin
    aligned_s = {addr_r[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};
    ext_lo_s  = (state_r == WAIT0) ? i_mem_rdata : lo_r;
    ext_hi_s  = (state_r == WAIT1) ? i_mem_rdata : {DATA_WIDTH{1'b0}};
  end

  load_extract #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFFS_W     (OFFS_W)
  ) u_extract (
    .hi     (ext_hi_s),
    .lo     (ext_lo_s),
    .offset (addr_r[OFFS_W-1:0]),
    .func_3 (func_3_r),
    .result (ext_data_s)
  );

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!i_req_valid) begin
          state_next_s = IDLE;
        end else if (illegal_s || (cross_s && !MISALIGN_SPLIT)) begin
          state_next_s = RESP;
        end else begin
          state_next_s = REQ0;
        end
      end
      REQ0:    state_next_s = i_mem_ready ? WAIT0 : REQ0;
      WAIT0:   state_next_s = i_mem_rvalid ? (cross_r ? REQ1 : RESP) : WAIT0;
      REQ1:    state_next_s = i_mem_ready ? WAIT1 : REQ1;
      WAIT1:   state_next_s = i_mem_rvalid ? RESP : WAIT1;
      RESP:    state_next_s = i_rsp_ready ? IDLE : RESP;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request capture, low-beat capture and response registers.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      addr_r     <= {ADDR_WIDTH{1'b0}};
      func_3_r   <= 3'b000;
      cross_r    <= 1'b0;
      lo_r       <= {DATA_WIDTH{1'b0}};
      rsp_data_r <= {DATA_WIDTH{1'b0}};
      ma_r       <= 1'b0;
      ill_r      <= 1'b0;
    end else begin
      if (state_r == IDLE && i_req_valid) begin
        addr_r   <= i_req_addr;
        func_3_r <= i_req_func_3;
        cross_r  <= cross_s;
      end
      if (state_r == WAIT0 && i_mem_rvalid) begin
        lo_r <= i_mem_rdata;
      end
      if (state_next_s == RESP && state_r != RESP) begin
        if (state_r == IDLE) begin
          rsp_data_r <= {DATA_WIDTH{1'b0}};
          ill_r      <= illegal_s;
          ma_r       <= ~illegal_s;
        end else begin
          rsp_data_r <= ext_data_s;
          ill_r      <= 1'b0;
          ma_r       <= 1'b0;
        end
      end
    end
  end

  // Output decode from the state register.
  always_comb begin
    o_req_ready     = (state_r == IDLE);
    o_mem_valid     = (state_r == REQ0) || (state_r == REQ1);
    o_rsp_valid     = (state_r == RESP);
    o_rsp_data      = rsp_data_r;
    o_load_addr_ma  = ma_r;
    o_illegal_instr = ill_r;
    case (state_r)
      REQ0:    o_mem_addr = aligned_s;
      REQ1:    o_mem_addr = aligned_s + ADDR_WIDTH'(BYTES);
      default: o_mem_addr = {ADDR_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: scoreboarded loads on a 64-bit split-capable
// instance, plus a no-split instance and a 32-bit instance for the error paths.
module tb_load_align_unit;
  import core_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic        ma;
    logic        ill;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arstn;
  int          checks = 0;
  int          errors = 0;
  rsp_t        rsp_q[$];
  logic [63:0] addr_q[$];

  // Main instance: 64-bit, split enabled
  logic        req_valid, req_ready, mem_valid, mem_ready, mem_rvalid;
  logic        rsp_valid, rsp_ready, load_ma, illegal;
  logic [63:0] req_addr, mem_addr, mem_rdata, rsp_data;
  logic [2:0]  req_f3;

  load_align_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .MISALIGN_SPLIT(1'b1)) dut (
    .i_clk(clk), .i_arstn(arstn),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr), .i_req_func_3(req_f3),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_load_addr_ma(load_ma), .o_illegal_instr(illegal)
  );

  // No-split instance
  logic        ns_req_valid, ns_req_ready, ns_mem_valid, ns_rsp_valid, ns_rsp_ready, ns_ma, ns_ill;
  logic [63:0] ns_req_addr, ns_mem_addr, ns_rsp_data;
  logic [2:0]  ns_req_f3;

  load_align_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .MISALIGN_SPLIT(1'b0)) dut_ns (
    .i_clk(clk), .i_arstn(arstn),
    .i_req_valid(ns_req_valid), .o_req_ready(ns_req_ready), .i_req_addr(ns_req_addr), .i_req_func_3(ns_req_f3),
    .o_mem_valid(ns_mem_valid), .i_mem_ready(1'b1), .o_mem_addr(ns_mem_addr),
    .i_mem_rvalid(1'b0), .i_mem_rdata(64'd0),
    .o_rsp_valid(ns_rsp_valid), .i_rsp_ready(ns_rsp_ready), .o_rsp_data(ns_rsp_data),
    .o_load_addr_ma(ns_ma), .o_illegal_instr(ns_ill)
  );

  // 32-bit instance
  logic        w_req_valid, w_req_ready, w_mem_valid, w_rsp_valid, w_rsp_ready, w_ma, w_ill;
  logic [63:0] w_req_addr, w_mem_addr;
  logic [31:0] w_rsp_data;
  logic [2:0]  w_req_f3;

  load_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(64), .MISALIGN_SPLIT(1'b1)) dut_w (
    .i_clk(clk), .i_arstn(arstn),
    .i_req_valid(w_req_valid), .o_req_ready(w_req_ready), .i_req_addr(w_req_addr), .i_req_func_3(w_req_f3),
    .o_mem_valid(w_mem_valid), .i_mem_ready(1'b1), .o_mem_addr(w_mem_addr),
    .i_mem_rvalid(1'b0), .i_mem_rdata(32'd0),
    .o_rsp_valid(w_rsp_valid), .i_rsp_ready(w_rsp_ready), .o_rsp_data(w_rsp_data),
    .o_load_addr_ma(w_ma), .o_illegal_instr(w_ill)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One load on the main instance with a responding memory; edges counts clock
  // edges from request acceptance to the response handshake.
  task automatic do_load(input string name, input logic [63:0] addr, input logic [2:0] f3,
                         input logic [63:0] lo, input logic [63:0] hi,
                         input logic [63:0] a0, input logic [63:0] a1, input int nreads,
                         input logic [63:0] edata, input logic ema, input logic eill,
                         input int exp_edges, input int mstall, input int rstall);
    int   edges = 0;
    int   reads = 0;
    int   ms = mstall;
    int   rs = rstall;
    bit   rv_pend = 1'b0;
    bit   done = 1'b0;
    rsp_t exp_rsp;
    rsp_q.push_back('{data: edata, ma: ema, ill: eill});
    if (nreads > 0) addr_q.push_back(a0);
    if (nreads > 1) addr_q.push_back(a1);
    @(negedge clk);
    check({name, " ready idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_f3    = f3;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; rsp_ready = 1'b0;
      edges++;
      if (rv_pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (reads == 1) ? lo : hi;
        rv_pend    = 1'b0;
      end
      if (mem_valid) begin
        check({name, " ready busy"}, 64'(req_ready), 64'd0);
        if (addr_q.size() == 0) begin
          check({name, " unexpected read"}, 64'(mem_valid), 64'd0);
        end else begin
          check({name, " mem addr"}, mem_addr, addr_q[0]);
          if (ms > 0) begin
            ms--;
          end else begin
            mem_ready = 1'b1;
            void'(addr_q.pop_front());
            reads++;
            rv_pend = 1'b1;
          end
        end
      end
      if (rsp_valid) begin
        exp_rsp = rsp_q[0];
        check({name, " rsp data"}, rsp_data, exp_rsp.data);
        check({name, " rsp ma"}, 64'(load_ma), 64'(exp_rsp.ma));
        check({name, " rsp ill"}, 64'(illegal), 64'(exp_rsp.ill));
        check({name, " ready in resp"}, 64'(req_ready), 64'd0);
        if (rs > 0) begin
          rs--;
        end else begin
          rsp_ready = 1'b1;
          void'(rsp_q.pop_front());
          done = 1'b1;
        end
      end
    end
    check({name, " completed"}, 64'(done), 64'd1);
    check({name, " read count"}, 64'(reads), 64'(nreads));
    if (mstall == 0 && rstall == 0) check({name, " latency"}, 64'(edges), 64'(exp_edges));
    @(negedge clk);
    rsp_ready = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b0;
    check({name, " back idle"}, 64'(req_ready), 64'd1);
    check({name, " rsp dropped"}, 64'(rsp_valid), 64'd0);
    rsp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    logic [2:0] bad32 [2];
    arstn = 1'b0;
    req_valid = 1'b0; req_addr = 64'd0; req_f3 = 3'b000;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0; rsp_ready = 1'b0;
    ns_req_valid = 1'b0; ns_req_addr = 64'd0; ns_req_f3 = 3'b000; ns_rsp_ready = 1'b0;
    w_req_valid = 1'b0; w_req_addr = 64'd0; w_req_f3 = 3'b000; w_rsp_ready = 1'b0;
    bad32[0] = F3_LD;
    bad32[1] = F3_LWU;

    repeat (2) @(negedge clk);
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset mem_valid", 64'(mem_valid), 64'd0);
    check("reset mem_addr", mem_addr, 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_data", rsp_data, 64'd0);
    check("reset ma", 64'(load_ma), 64'd0);
    check("reset ill", 64'(illegal), 64'd0);
    arstn = 1'b1;

    do_load("lb", 64'h1003, F3_LB, 64'h0000_0000_8000_0000, 64'd0, 64'h1000, 64'd0, 1,
            64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0, 3, 0, 0);
    do_load("lhu split", 64'h2007, F3_LHU, 64'hAB00_0000_0000_0000, 64'h1122_3344_5566_00CD,
            64'h2000, 64'h2008, 2, 64'h0000_0000_0000_CDAB, 1'b0, 1'b0, 5, 0, 0);
    do_load("f3 111", 64'h4000, F3_BAD, 64'd0, 64'd0, 64'd0, 64'd0, 0,
            64'd0, 1'b0, 1'b1, 1, 0, 0);
    do_load("lh inword", 64'h3001, F3_LH, 64'h0000_0000_00BE_EF00, 64'd0, 64'h3000, 64'd0, 1,
            64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 1'b0, 3, 0, 0);
    do_load("lwu", 64'h4004, F3_LWU, 64'h8765_4321_0000_0000, 64'd0, 64'h4000, 64'd0, 1,
            64'h0000_0000_8765_4321, 1'b0, 1'b0, 3, 0, 0);
    do_load("ld", 64'h5000, F3_LD, 64'h0123_4567_89AB_CDEF, 64'd0, 64'h5000, 64'd0, 1,
            64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 3, 0, 0);
    do_load("lw split", 64'h6006, F3_LW, 64'hBBAA_0000_0000_0000, 64'h0000_0000_0000_DDCC,
            64'h6000, 64'h6008, 2, 64'hFFFF_FFFF_DDCC_BBAA, 1'b0, 1'b0, 5, 0, 0);
    do_load("backpressure", 64'h7005, F3_LBU, 64'h0000_5A00_0000_0000, 64'd0, 64'h7000, 64'd0, 1,
            64'h0000_0000_0000_005A, 1'b0, 1'b0, 0, 3, 2);
    do_load("ld wrap", 64'hFFFF_FFFF_FFFF_FFFC, F3_LD, 64'hAABB_CCDD_0000_0000, 64'h0000_0000_1122_3344,
            64'hFFFF_FFFF_FFFF_FFF8, 64'h0000_0000_0000_0000, 2, 64'h1122_3344_AABB_CCDD,
            1'b0, 1'b0, 5, 0, 0);

    // Reset while the second beat of a split load is outstanding
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h2007; req_f3 = F3_LHU;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst seq req0", 64'(mem_valid), 64'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hAB00_0000_0000_0000;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rst seq req1 addr", mem_addr, 64'h2008);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("rst seq wait1 ready", 64'(req_ready), 64'd0);
    #1 arstn = 1'b0;
    #1 check("async reset ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    check("after reset ready", 64'(req_ready), 64'd1);
    check("after reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("after reset mem_addr", mem_addr, 64'd0);
    arstn = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344_5566_00CD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late rvalid ready", 64'(req_ready), 64'd1);
    check("late rvalid rsp_valid", 64'(rsp_valid), 64'd0);
    check("late rvalid mem_valid", 64'(mem_valid), 64'd0);
    do_load("lw after reset", 64'h0, F3_LW, 64'h0000_0000_F000_0001, 64'd0, 64'h0, 64'd0, 1,
            64'hFFFF_FFFF_F000_0001, 1'b0, 1'b0, 3, 0, 0);

    // Crossing load rejected when splitting is disabled
    @(negedge clk);
    ns_req_valid = 1'b1; ns_req_addr = 64'h2007; ns_req_f3 = F3_LHU;
    @(negedge clk);
    ns_req_valid = 1'b0;
    check("nosplit rsp_valid", 64'(ns_rsp_valid), 64'd1);
    check("nosplit ma", 64'(ns_ma), 64'd1);
    check("nosplit ill", 64'(ns_ill), 64'd0);
    check("nosplit data", ns_rsp_data, 64'd0);
    check("nosplit mem_valid", 64'(ns_mem_valid), 64'd0);
    ns_rsp_ready = 1'b1;
    @(negedge clk);
    ns_rsp_ready = 1'b0;
    check("nosplit idle", 64'(ns_req_ready), 64'd1);
    check("nosplit mem_addr", ns_mem_addr, 64'd0);

    // LD and LWU are illegal on the 32-bit instance
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      w_req_valid = 1'b1; w_req_addr = 64'h10; w_req_f3 = bad32[k];
      @(negedge clk);
      w_req_valid = 1'b0;
      check("w32 rsp_valid", 64'(w_rsp_valid), 64'd1);
      check("w32 ill", 64'(w_ill), 64'd1);
      check("w32 ma", 64'(w_ma), 64'd0);
      check("w32 data", 64'(w_rsp_data), 64'd0);
      check("w32 mem_valid", 64'(w_mem_valid), 64'd0);
      w_rsp_ready = 1'b1;
      @(negedge clk);
      w_rsp_ready = 1'b0;
      check("w32 idle", 64'(w_req_ready), 64'd1);
      check("w32 mem_addr", w_mem_addr, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
